// File: rtl/dir_cmd_scheduler_pkg.sv
// Shared definitions for the direction command scheduler.
// Holds the direction encodings, the opposite-direction helper and the
// key-select helper that resolves several simultaneous key flags.
package dir_cmd_scheduler_pkg;

    localparam int unsigned DIR_W = 2;

    // Direction encodings; opposite pairs differ only in bit 0.
    localparam logic [DIR_W-1:0] TOP_DIR   = 2'd0;
    localparam logic [DIR_W-1:0] DOWN_DIR  = 2'd1;
    localparam logic [DIR_W-1:0] LEFT_DIR  = 2'd2;
    localparam logic [DIR_W-1:0] RIGHT_DIR = 2'd3;

    // Selected key for the current cycle.
    typedef struct packed {
        logic             valid;
        logic [DIR_W-1:0] dir;
    } keySel_t;

    // Opposite direction: flip bit 0 of the encoding.
    function automatic logic [DIR_W-1:0] oppDir(input logic [DIR_W-1:0] d);
        return d ^ 2'b01;
    endfunction

    // Priority Up > Down > Left > Right; lower flags are discarded.
    function automatic keySel_t selectKey(input logic up, input logic down,
                                          input logic left, input logic right);
        keySel_t k;
        k.valid = up | down | left | right;
        if (up)        k.dir = TOP_DIR;
        else if (down) k.dir = DOWN_DIR;
        else if (left) k.dir = LEFT_DIR;
        else           k.dir = RIGHT_DIR;
        return k;
    endfunction

endpackage

// File: rtl/dir_cmd_scheduler_dir_fifo.sv
// dir_fifo: synchronous FIFO of DEPTH two-bit direction entries.
// Ports:
//   iClk, iRst_n   clock, synchronous active-low reset
//   iClear         synchronous flush (same effect as reset)
//   iPush, iData   write request and data; taken when not full or when popping
//   iPop           read request; ignored when empty
//   oHead_c        oldest entry (combinational read of storage)
//   oTail_c        newest entry (combinational read of storage)
//   oFull_c        count == DEPTH
//   oEmpty_c       count == 0
//   oCount         registered occupancy, 0..DEPTH
module dir_fifo
    import dir_cmd_scheduler_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iClear,
    input  logic             iPush,
    input  logic             iPop,
    input  logic [DIR_W-1:0] iData,
    output logic [DIR_W-1:0] oHead_c,
    output logic [DIR_W-1:0] oTail_c,
    output logic             oFull_c,
    output logic             oEmpty_c,
    output logic [PTR_W:0]   oCount
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DIR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic             pushOk;
    logic             popOk;

    // Flags and qualified requests; a push into a full FIFO needs a pop.
    always_comb begin
        oFull_c  = (oCount == FULL_CNT);
        oEmpty_c = (oCount == '0);
        popOk    = iPop && !oEmpty_c;
        pushOk   = iPush && (!oFull_c || popOk);
        oHead_c  = mem[rdPtr];
        oTail_c  = mem[wrPtr - PTR_W'(1)];
    end

    // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
    always_ff @(posedge iClk) begin
        if (!iRst_n || iClear) begin
            rdPtr  <= '0;
            wrPtr  <= '0;
            oCount <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
            if (popOk)  rdPtr <= rdPtr + PTR_W'(1);
            case ({pushOk, popOk})
                2'b10:   oCount <= oCount + (PTR_W+1)'(1);
                2'b01:   oCount <= oCount - (PTR_W+1)'(1);
                default: oCount <= oCount;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted.
    always_ff @(posedge iClk) begin
        if (pushOk) mem[wrPtr] <= iData;
    end

endmodule

// File: rtl/dir_cmd_scheduler.sv
// dir_cmd_scheduler: queues debounced direction key flags and applies one
// per game step, never letting an applied direction reverse the previous one.
// Ports:
//   iClk, iRst_n                    clock, synchronous active-low reset
//   iF_kUp/Down/Left/Right          one-cycle debounced key flags
//   iRun                            1 = step counter runs, 0 = held at 0
//   iClear                          synchronous restart (same as reset)
//   oDirection                      applied direction
//   oStep                           one-cycle game-step pulse
//   oQ_count                        queued commands, 0..DEPTH
//   oDrop                           one-cycle pulse: a key flag was rejected
module dir_cmd_scheduler
    import dir_cmd_scheduler_pkg::*;
#(
    parameter  int unsigned DEPTH       = 4,
    parameter  int unsigned TICK_CYCLES = 5_000_000,
    localparam int unsigned CNT_W       = $clog2(TICK_CYCLES),
    localparam int unsigned PTR_W       = $clog2(DEPTH)
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iF_kUp,
    input  logic             iF_kDown,
    input  logic             iF_kLeft,
    input  logic             iF_kRight,
    input  logic             iRun,
    input  logic             iClear,
    output logic [DIR_W-1:0] oDirection,
    output logic             oStep,
    output logic [PTR_W:0]   oQ_count,
    output logic             oDrop
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] stepCnt;
    keySel_t          key;
    logic             stepNow;
    logic             doPop;
    logic             doPush;
    logic             reject;
    logic [DIR_W-1:0] refDir;
    logic [DIR_W-1:0] headDir;
    logic [DIR_W-1:0] tailDir;
    logic             fifoFull;
    logic             fifoEmpty;

    dir_fifo #(.DEPTH(DEPTH)) uFifo (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iClear   (iClear),
        .iPush    (doPush),
        .iPop     (doPop),
        .iData    (key.dir),
        .oHead_c  (headDir),
        .oTail_c  (tailDir),
        .oFull_c  (fifoFull),
        .oEmpty_c (fifoEmpty),
        .oCount   (oQ_count)
    );

    // Accept logic: the new key is checked against the pre-pop tail, or the
    // applied direction when nothing is queued.
    always_comb begin
        key     = selectKey(iF_kUp, iF_kDown, iF_kLeft, iF_kRight);
        stepNow = iRun && (stepCnt == LAST_CNT);
        doPop   = stepNow && !fifoEmpty;
        refDir  = fifoEmpty ? oDirection : tailDir;
        reject  = key.valid && ((key.dir == refDir) ||
                                (key.dir == oppDir(refDir)) ||
                                (fifoFull && !doPop));
        doPush  = key.valid && !reject;
    end

    // Step counter and registered outputs.
    always_ff @(posedge iClk) begin
        if (!iRst_n || iClear) begin
            stepCnt    <= '0;
            oStep      <= 1'b0;
            oDrop      <= 1'b0;
            oDirection <= TOP_DIR;
        end else begin
            if (!iRun || stepNow) stepCnt <= '0;
            else                  stepCnt <= stepCnt + CNT_W'(1);
            oStep <= stepNow;
            oDrop <= reject;
            if (doPop) oDirection <= headDir;
        end
    end

endmodule
